// File: rtl/operand_fetch.sv
// operand_fetch: 8-entry register file feeding a sequenced two-operand fetch FSM
module operand_fetch #(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [2:0]        rn,
  input  logic [2:0]        rm,
  input  logic [1:0]        shift_in,
  input  logic              write,
  input  logic [2:0]        writenum,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] a_out,
  output logic [DATA_W-1:0] b_out,
  output logic [1:0]        shift_out,
  output logic              busy,
  output logic              done
);
  typedef enum logic [1:0] {IDLE, RD_A, RD_B, DONE} state_t;
  state_t state, state_nx;
  logic [DATA_W-1:0] regs [8];
  logic [2:0] rn_q, rm_q;
  logic [DATA_W-1:0] rd_a, rd_b;
  // next state, status flags and write-first read ports
  always_comb begin
    state_nx = state == IDLE ? (start ? RD_A : IDLE) :
               state == RD_A ? RD_B :
               state == RD_B ? DONE : IDLE;
    busy = state != IDLE;
    done = state == DONE;
    rd_a = write && writenum == rn_q ? data_in : regs[rn_q];
    rd_b = write && writenum == rm_q ? data_in : regs[rm_q];
  end
  // register file, writable in every state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) for (int i = 0; i < 8; i++) regs[i] <= '0;
    else if (write) regs[writenum] <= data_in;
  end
  // state register, request capture and operand latches
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      rn_q      <= '0;
      rm_q      <= '0;
      a_out     <= '0;
      b_out     <= '0;
      shift_out <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && start) begin
        rn_q      <= rn;
        rm_q      <= rm;
        shift_out <= shift_in;
      end
      if (state == RD_A) a_out <= rd_a;
      if (state == RD_B) b_out <= rd_b;
    end
  end
endmodule

// File: tb/tb_operand_fetch.sv
// tb_operand_fetch: scoreboard bench for the operand fetch block
module tb_operand_fetch;
  logic clk = 0, reset = 1, start = 0, write = 0;
  logic [2:0] rn = 0, rm = 0, writenum = 0;
  logic [1:0] shift_in = 0;
  logic [15:0] data_in = 0;
  logic [15:0] a_out, b_out;
  logic [1:0] shift_out;
  logic busy, done;
  int compared = 0, mismatched = 0;
  logic [33:0] exp_q[$];
  logic prev_done = 0;

  operand_fetch #(.DATA_W(16)) dut (
    .clk(clk), .reset(reset), .start(start), .rn(rn), .rm(rm),
    .shift_in(shift_in), .write(write), .writenum(writenum), .data_in(data_in),
    .a_out(a_out), .b_out(b_out), .shift_out(shift_out), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (done) begin
      logic [33:0] e;
      compared++;
      if (prev_done) begin
        mismatched++;
        $display("FAIL done_width: done high two cycles in a row, expected one");
      end
      compared++;
      if (exp_q.size() == 0) begin
        mismatched++;
        $display("FAIL unexpected_done: a=%h b=%h sh=%b with no fetch pending", a_out, b_out, shift_out);
      end else begin
        e = exp_q.pop_front();
        if ({a_out, b_out, shift_out} !== e) begin
          mismatched++;
          $display("FAIL result: got a=%h b=%h sh=%b expected a=%h b=%h sh=%b",
                   a_out, b_out, shift_out, e[33:18], e[17:2], e[1:0]);
        end
      end
    end
    prev_done <= done;
  end

  task automatic wr(input logic [2:0] n, input logic [15:0] d);
    write = 1; writenum = n; data_in = d;
    @(negedge clk);
    write = 0;
  endtask

  task automatic start_fetch(input logic [2:0] a, input logic [2:0] b, input logic [1:0] s,
                             input logic [15:0] ea, input logic [15:0] eb);
    exp_q.push_back({ea, eb, s});
    start = 1; rn = a; rm = b; shift_in = s;
    @(negedge clk);
    start = 0;
    check("shift_capture", 32'(shift_out), 32'(s));
  endtask

  task automatic fetch(input logic [2:0] a, input logic [2:0] b, input logic [1:0] s,
                       input logic [15:0] ea, input logic [15:0] eb);
    int n;
    start_fetch(a, b, s, ea, eb);
    n = int'(busy);
    repeat (3) begin
      @(negedge clk);
      n += int'(busy);
    end
    check("busy_cycles", 32'(n), 32'd3);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    #1;
    check("rst_a", 32'(a_out), 0);
    check("rst_b", 32'(b_out), 0);
    check("rst_shift", 32'(shift_out), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    @(negedge clk);
    reset = 0;
    fetch(0, 0, 2'b10, 16'h0000, 16'h0000);
    wr(3, 16'b1111000011001111);
    wr(5, 16'h00FF);
    fetch(5, 3, 2'b01, 16'h00FF, 16'hF0CF);
    fetch(5, 5, 2'b10, 16'h00FF, 16'h00FF);
    repeat (3) @(negedge clk);
    check("shift_hold", 32'(shift_out), 32'b10);
    check("a_hold", 32'(a_out), 32'h00FF);
    fetch(3, 3, 2'b11, 16'hF0CF, 16'hF0CF);
    wr(2, 16'hFFFF);
    fetch(2, 2, 2'b00, 16'hFFFF, 16'hFFFF);
    wr(4, 16'hAAAA);
    start_fetch(3, 4, 2'b00, 16'hF0CF, 16'h1234);
    @(negedge clk);
    wr(4, 16'h1234);
    @(negedge clk);
    start_fetch(3, 4, 2'b00, 16'hF0CF, 16'h1234);
    @(negedge clk);
    wr(6, 16'h5678);
    @(negedge clk);
    fetch(6, 4, 2'b01, 16'h5678, 16'h1234);
    start_fetch(3, 5, 2'b01, 16'hF0CF, 16'h00FF);
    start = 1; rn = 2; rm = 2; shift_in = 2'b11;
    @(negedge clk);
    rm = 6;
    @(negedge clk);
    start = 0;
    repeat (5) @(negedge clk);
    check("no_refetch_busy", 32'(busy), 0);
    check("no_refetch_shift", 32'(shift_out), 32'b01);
    start = 1; rn = 5; rm = 3; shift_in = 2'b11;
    @(negedge clk);
    start = 0;
    #2 reset = 1;
    #1;
    check("arst_a", 32'(a_out), 0);
    check("arst_b", 32'(b_out), 0);
    check("arst_shift", 32'(shift_out), 0);
    check("arst_busy", 32'(busy), 0);
    check("arst_done", 32'(done), 0);
    @(negedge clk);
    start = 1; write = 1; writenum = 7; data_in = 16'hBEEF;
    @(negedge clk);
    start = 0; write = 0; reset = 0;
    repeat (5) @(negedge clk);
    check("post_rst_busy", 32'(busy), 0);
    fetch(0, 1, 2'b00, 16'h0000, 16'h0000);
    fetch(2, 3, 2'b00, 16'h0000, 16'h0000);
    fetch(4, 5, 2'b00, 16'h0000, 16'h0000);
    fetch(6, 7, 2'b00, 16'h0000, 16'h0000);
    repeat (3) @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
